// File: rtl/addsub_pkg.sv
// addsub_pkg: shared types and constants for the add/sub accumulator slice.
// Contents: FSM state type, default total width / op limit, upstream result width.
package addsub_pkg;

    typedef enum logic [1:0] {IDLE, CAPTURE, ADD, FULL_ST} state_t;

    localparam int ACC_W_DEF   = 8;
    localparam int MAX_OPS_DEF = 15;
    localparam int SUM_W       = 4;

endpackage

// File: rtl/addsub_accumulator_if.sv
// addsub_accumulator_if: result-in / total-out bundle between upstream and accumulator.
// Signals: SUM_IN, OVF_IN, IN_VALID, CLEAR (upstream -> accumulator);
//          IN_READY, ACC, ACC_VALID, STICKY_OVF, ACC_OVF, COUNT, FULL (accumulator -> upstream).
// Modports: master = upstream driver, slave = accumulator.
interface addsub_accumulator_if
    import addsub_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
);
    logic signed [SUM_W-1:0] SUM_IN;
    logic                    OVF_IN;
    logic                    IN_VALID;
    logic                    IN_READY;
    logic                    CLEAR;
    logic signed [ACC_W-1:0] ACC;
    logic                    ACC_VALID;
    logic                    STICKY_OVF;
    logic                    ACC_OVF;
    logic [3:0]              COUNT;
    logic                    FULL;

    modport master (
        output SUM_IN, OVF_IN, IN_VALID, CLEAR,
        input  IN_READY, ACC, ACC_VALID, STICKY_OVF, ACC_OVF, COUNT, FULL
    );

    modport slave (
        input  SUM_IN, OVF_IN, IN_VALID, CLEAR,
        output IN_READY, ACC, ACC_VALID, STICKY_OVF, ACC_OVF, COUNT, FULL
    );
endinterface

// File: rtl/acc_sat_add.sv
// acc_sat_add: combinational W-bit signed adder with overflow flag and optional clamp.
// Ports: a, b (signed addends), sum (result), ovf (signed overflow of a+b).
// Config: ADDSUB_ACC_SATURATE_EN defined -> sum clamps to the signed limit on overflow;
//         undefined -> sum wraps modulo 2^W.
module acc_sat_add #(
    parameter int W = 8
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] sum,
    output logic                ovf
);
    logic signed [W-1:0] raw;

    assign raw = a + b;
    // Overflow only possible when both addends share a sign that the result lacks.
    assign ovf = (a[W-1] == b[W-1]) && (raw[W-1] != a[W-1]);

`ifdef ADDSUB_ACC_SATURATE_EN
    assign sum = !ovf ? raw : a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`else
    assign sum = raw;
`endif
endmodule

// File: rtl/addsub_accumulator.sv
// addsub_accumulator: accumulates signed 4-bit upstream results into a signed running total.
// Ports: CLOCK_50 (clock), RESETN (sync active-low reset), bus (addsub_accumulator_if.slave).
// Flow: IDLE accepts -> CAPTURE sign-extends -> ADD updates total; FULL_ST after MAX_OPS results.
// Config: ADDSUB_ACC_SATURATE_EN selects clamping instead of wrapping on total overflow.
module addsub_accumulator
    import addsub_pkg::*;
#(
    parameter int ACC_W   = ACC_W_DEF,
    parameter int MAX_OPS = MAX_OPS_DEF
) (
    input logic                 CLOCK_50,
    input logic                 RESETN,
    addsub_accumulator_if.slave bus
);
    localparam logic [3:0] MAX_C = 4'(MAX_OPS);

    state_t                  state, state_nx;
    logic signed [SUM_W-1:0] op_raw;
    logic signed [ACC_W-1:0] op_ext;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] sum;
    logic                    add_ovf;
    logic                    accept;
    logic [3:0]              count;
    logic [3:0]              count_nx;
    logic                    acc_valid;
    logic                    sticky_ovf;
    logic                    acc_ovf;

    // CLEAR beats a simultaneous handshake, so it also vetoes acceptance.
    assign accept   = (state == IDLE) && bus.IN_VALID && !bus.CLEAR;
    assign count_nx = count + 4'd1;

    acc_sat_add #(.W(ACC_W)) u_add (
        .a   (acc),
        .b   (op_ext),
        .sum (sum),
        .ovf (add_ovf)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? CAPTURE : IDLE;
            CAPTURE: state_nx = ADD;
            ADD:     state_nx = (count_nx == MAX_C) ? FULL_ST : IDLE;
            FULL_ST: state_nx = FULL_ST;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!RESETN || bus.CLEAR) begin
            state      <= IDLE;
            op_raw     <= '0;
            op_ext     <= '0;
            acc        <= '0;
            count      <= '0;
            acc_valid  <= 1'b0;
            sticky_ovf <= 1'b0;
            acc_ovf    <= 1'b0;
        end else begin
            state     <= state_nx;
            acc_valid <= (state == ADD);
            if (accept) begin
                op_raw     <= bus.SUM_IN;
                sticky_ovf <= sticky_ovf | bus.OVF_IN;
            end
            if (state == CAPTURE)
                op_ext <= ACC_W'(op_raw);
            if (state == ADD) begin
                acc     <= sum;
                count   <= count_nx;
                acc_ovf <= acc_ovf | add_ovf;
            end
        end
    end

    assign bus.IN_READY   = (state == IDLE);
    assign bus.ACC        = acc;
    assign bus.ACC_VALID  = acc_valid;
    assign bus.STICKY_OVF = sticky_ovf;
    assign bus.ACC_OVF    = acc_ovf;
    assign bus.COUNT      = count;
    assign bus.FULL       = (count == MAX_C);
endmodule

// File: tb/tb_addsub_accumulator.sv
// tb_addsub_accumulator: directed bench for addsub_accumulator (ACC_W=8 and ACC_W=4 instances).
module tb_addsub_accumulator;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    addsub_accumulator_if #(.ACC_W(8)) b1 ();
    addsub_accumulator_if #(.ACC_W(4)) b2 ();

    addsub_accumulator #(.ACC_W(8), .MAX_OPS(15)) dut8 (
        .CLOCK_50 (clk),
        .RESETN   (resetn),
        .bus      (b1.slave)
    );

    addsub_accumulator #(.ACC_W(4), .MAX_OPS(15)) dut4 (
        .CLOCK_50 (clk),
        .RESETN   (resetn),
        .bus      (b2.slave)
    );

    typedef struct {
        logic              clr;
        logic [3:0]        sum;
        logic              ovf;
        logic signed [7:0] acc;
        logic [3:0]        cnt;
        logic              sticky;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_clear();
        b1.CLEAR = 1'b1;
        @(negedge clk);
        b1.CLEAR = 1'b0;
        chk("clr_acc", 32'(b1.ACC), 32'(0));
        chk("clr_cnt", 32'(b1.COUNT), 32'(0));
        chk("clr_sticky", 32'(b1.STICKY_OVF), 32'(0));
        chk("clr_accovf", 32'(b1.ACC_OVF), 32'(0));
        chk("clr_full", 32'(b1.FULL), 32'(0));
        chk("clr_ready", 32'(b1.IN_READY), 32'(1));
    endtask

    // Handshake one result on the 8-bit DUT and check the 3-cycle ACC_VALID latency.
    task automatic send(input logic [3:0] v, input logic o);
        int n = 0;
        while (!b1.IN_READY && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", 32'(b1.IN_READY), 32'(1));
        b1.SUM_IN   = v;
        b1.OVF_IN   = o;
        b1.IN_VALID = 1'b1;
        @(negedge clk);
        b1.IN_VALID = 1'b0;
        b1.OVF_IN   = 1'b0;
        chk("lat1_valid", 32'(b1.ACC_VALID), 32'(0));
        chk("lat1_ready", 32'(b1.IN_READY), 32'(0));
        @(negedge clk);
        chk("lat2_valid", 32'(b1.ACC_VALID), 32'(0));
        @(negedge clk);
        chk("lat3_valid", 32'(b1.ACC_VALID), 32'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic signed [3:0] exp4;
        vecs[0] = '{1'b1, 4'h3, 1'b0,  8'sd3, 4'd1, 1'b0};
        vecs[1] = '{1'b1, 4'h5, 1'b0,  8'sd5, 4'd1, 1'b0};
        vecs[2] = '{1'b0, 4'hD, 1'b0,  8'sd2, 4'd2, 1'b0};
        vecs[3] = '{1'b0, 4'h1, 1'b1,  8'sd3, 4'd3, 1'b1};
        vecs[4] = '{1'b0, 4'h2, 1'b0,  8'sd5, 4'd4, 1'b1};
        vecs[5] = '{1'b0, 4'h8, 1'b0, -8'sd3, 4'd5, 1'b1};
        vecs[6] = '{1'b0, 4'hF, 1'b0, -8'sd4, 4'd6, 1'b1};

        b1.SUM_IN = '0; b1.OVF_IN = 1'b0; b1.IN_VALID = 1'b0; b1.CLEAR = 1'b0;
        b2.SUM_IN = '0; b2.OVF_IN = 1'b0; b2.IN_VALID = 1'b0; b2.CLEAR = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_acc", 32'(b1.ACC), 32'(0));
        chk("rst_cnt", 32'(b1.COUNT), 32'(0));
        chk("rst_sticky", 32'(b1.STICKY_OVF), 32'(0));
        chk("rst_accovf", 32'(b1.ACC_OVF), 32'(0));
        chk("rst_valid", 32'(b1.ACC_VALID), 32'(0));
        chk("rst_full", 32'(b1.FULL), 32'(0));
        chk("rst_ready", 32'(b1.IN_READY), 32'(1));
        chk("rst4_acc", 32'(b2.ACC), 32'(0));
        resetn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            if (vecs[i].clr) do_clear();
            send(vecs[i].sum, vecs[i].ovf);
            chk($sformatf("v%0d_acc", i), 32'(b1.ACC), 32'(vecs[i].acc));
            chk($sformatf("v%0d_cnt", i), 32'(b1.COUNT), 32'(vecs[i].cnt));
            chk($sformatf("v%0d_sticky", i), 32'(b1.STICKY_OVF), 32'(vecs[i].sticky));
            chk($sformatf("v%0d_accovf", i), 32'(b1.ACC_OVF), 32'(0));
        end

        // Fill to MAX_OPS with 7s, then keep offering input while full.
        do_clear();
        for (int i = 0; i < 15; i++) send(4'h7, 1'b0);
        chk("full_acc", 32'(b1.ACC), 32'(105));
        chk("full_cnt", 32'(b1.COUNT), 32'(15));
        chk("full_flag", 32'(b1.FULL), 32'(1));
        chk("full_ready", 32'(b1.IN_READY), 32'(0));
        b1.SUM_IN = 4'h7;
        b1.IN_VALID = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk("full_novalid", 32'(b1.ACC_VALID), 32'(0));
        end
        b1.IN_VALID = 1'b0;
        chk("full_hold_acc", 32'(b1.ACC), 32'(105));
        chk("full_hold_cnt", 32'(b1.COUNT), 32'(15));
        chk("full_hold_ready", 32'(b1.IN_READY), 32'(0));
        do_clear();

        // CLEAR during ADD with IN_VALID held high.
        send(4'h2, 1'b1);
        chk("pre_clr_acc", 32'(b1.ACC), 32'(2));
        b1.SUM_IN = 4'h3;
        b1.IN_VALID = 1'b1;
        @(negedge clk);
        chk("busy_ready", 32'(b1.IN_READY), 32'(0));
        @(negedge clk);
        b1.CLEAR = 1'b1;
        @(negedge clk);
        b1.CLEAR = 1'b0;
        b1.IN_VALID = 1'b0;
        chk("addclr_acc", 32'(b1.ACC), 32'(0));
        chk("addclr_cnt", 32'(b1.COUNT), 32'(0));
        chk("addclr_sticky", 32'(b1.STICKY_OVF), 32'(0));
        chk("addclr_valid", 32'(b1.ACC_VALID), 32'(0));
        chk("addclr_ready", 32'(b1.IN_READY), 32'(1));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("addclr_novalid", 32'(b1.ACC_VALID), 32'(0));
        end
        chk("addclr_acc2", 32'(b1.ACC), 32'(0));
        chk("addclr_cnt2", 32'(b1.COUNT), 32'(0));

        // Reset while the operand is in CAPTURE; CLEAR asserted too but reset wins.
        send(4'h4, 1'b0);
        chk("pre_rst_acc", 32'(b1.ACC), 32'(4));
        b1.SUM_IN = 4'h5;
        b1.IN_VALID = 1'b1;
        @(negedge clk);
        b1.IN_VALID = 1'b0;
        resetn = 1'b0;
        b1.CLEAR = 1'b1;
        @(negedge clk);
        resetn = 1'b1;
        b1.CLEAR = 1'b0;
        chk("midrst_acc", 32'(b1.ACC), 32'(0));
        chk("midrst_cnt", 32'(b1.COUNT), 32'(0));
        chk("midrst_ready", 32'(b1.IN_READY), 32'(1));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("midrst_novalid", 32'(b1.ACC_VALID), 32'(0));
        end
        chk("midrst_acc2", 32'(b1.ACC), 32'(0));

        // ACC_W=4 overflow: 7 + 7.
`ifdef ADDSUB_ACC_SATURATE_EN
        exp4 = 4'sd7;
`else
        exp4 = -4'sd2;
`endif
        b2.SUM_IN = 4'h7;
        b2.IN_VALID = 1'b1;
        @(negedge clk);
        b2.IN_VALID = 1'b0;
        repeat (2) @(negedge clk);
        chk("w4_first_valid", 32'(b2.ACC_VALID), 32'(1));
        chk("w4_first_acc", 32'(b2.ACC), 32'(4'sd7));
        chk("w4_first_ovf", 32'(b2.ACC_OVF), 32'(0));
        b2.IN_VALID = 1'b1;
        @(negedge clk);
        b2.IN_VALID = 1'b0;
        repeat (2) @(negedge clk);
        chk("w4_second_valid", 32'(b2.ACC_VALID), 32'(1));
        chk("w4_second_acc", 32'(b2.ACC), 32'(exp4));
        chk("w4_second_ovf", 32'(b2.ACC_OVF), 32'(1));
        chk("w4_second_cnt", 32'(b2.COUNT), 32'(2));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
